// File: rtl/adc_scan_scheduler.sv
// rtl/adc_scan_scheduler.sv - round-robin multi-channel ADC scan scheduler feeding the FIR sample strobe
module adc_scan_scheduler #(
  parameter int N_CH    = 4,
  parameter int DATA_W  = 12,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      enable_in,
  input  logic [N_CH-1:0]           ch_en_in,
  input  logic [5*N_CH-1:0]         ch_map_in,
  input  logic [8:0]                sampl_time_in,
  output logic [4:0]                chsel_out,
  output logic                      soc_out,
  input  logic                      eoc_in,
  input  logic [DATA_W-1:0]         dout_in,
  output logic                      fir_start_out,
  output logic [DATA_W-1:0]         fir_x_out,
  output logic [$clog2(N_CH)-1:0]   ch_tag_out,
  output logic                      busy_out,
  output logic                      overrun_out,
  output logic                      timeout_out
);

  localparam int CW = $clog2(N_CH);
  localparam int PW = $clog2(N_CH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    SELECT,
    SETTLE,
    SOC,
    CONV,
    LATCH
  } state_t;

  state_t            state;
  logic [8:0]        period_cnt;
  logic              trig_pend;
  logic [N_CH-1:0]   scan_mask;
  logic [PW-1:0]     ptr;
  logic [CW-1:0]     cur_ch;
  logic [TW-1:0]     to_cnt;
  logic              settle_cnt;
  logic              eoc_q;
  logic              eoc_d;

  logic [CW-1:0]     sel_ch;
  logic [4:0]        sel_phys;
  logic [N_CH-1:0]   cur_bit;
  logic [N_CH-1:0]   rest_mask;
  logic              eoc_edge;
  logic              conv_timeout;
  logic              ch_done;
  logic              trig_take;

  // Lowest still-pending channel at or above the scan pointer, and its physical ADC input.
  always_comb begin
    sel_ch   = '0;
    sel_phys = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (scan_mask[i] && (PW'(i) >= ptr)) begin
        sel_ch   = CW'(i);
        sel_phys = ch_map_in[5*i +: 5];
      end
    end
  end

  assign eoc_edge     = eoc_q & ~eoc_d;
  assign conv_timeout = (state == CONV) && !eoc_edge && (to_cnt <= TW'(1));
  assign ch_done      = (state == LATCH) || conv_timeout;
  assign cur_bit      = N_CH'(1) << cur_ch;
  assign rest_mask    = scan_mask & ~cur_bit;
  assign trig_take    = (state == WAIT) && enable_in && trig_pend;

  // EOC is registered once; the previous registered value gives the rising edge.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      eoc_q <= 1'b0;
      eoc_d <= 1'b0;
    end else begin
      eoc_q <= eoc_in;
      eoc_d <= eoc_q;
    end
  end

  // Free-running scan period: reloads on expiry and queues at most one trigger.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      period_cnt  <= '0;
      trig_pend   <= 1'b0;
      overrun_out <= 1'b0;
    end else begin
      overrun_out <= 1'b0;
      if (state == IDLE) begin
        if (enable_in) begin
          period_cnt <= sampl_time_in;
          trig_pend  <= 1'b1;
        end else begin
          trig_pend  <= 1'b0;
        end
      end else if (period_cnt == '0) begin
        period_cnt  <= sampl_time_in;
        trig_pend   <= 1'b1;
        overrun_out <= trig_pend && !trig_take;
      end else begin
        period_cnt <= period_cnt - 9'd1;
        if (trig_take) begin
          trig_pend <= 1'b0;
        end
      end
    end
  end

  // Scan sequencer: select, settle, start, convert, latch, then advance to the next channel.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= IDLE;
      scan_mask     <= '0;
      ptr           <= '0;
      cur_ch        <= '0;
      to_cnt        <= '0;
      settle_cnt    <= 1'b0;
      chsel_out     <= '0;
      soc_out       <= 1'b0;
      fir_start_out <= 1'b0;
      fir_x_out     <= '0;
      ch_tag_out    <= '0;
      busy_out      <= 1'b0;
      timeout_out   <= 1'b0;
    end else begin
      soc_out       <= 1'b0;
      fir_start_out <= 1'b0;
      timeout_out   <= 1'b0;
      case (state)
        IDLE: begin
          if (enable_in) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (!enable_in) begin
            state     <= IDLE;
            scan_mask <= '0;
          end else if (trig_pend && (ch_en_in != '0)) begin
            scan_mask <= ch_en_in;
            ptr       <= '0;
            busy_out  <= 1'b1;
            state     <= SELECT;
          end
        end
        SELECT: begin
          cur_ch     <= sel_ch;
          chsel_out  <= sel_phys;
          settle_cnt <= 1'b0;
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt) begin
            soc_out <= 1'b1;
            to_cnt  <= TW'(TIMEOUT);
            state   <= SOC;
          end else begin
            settle_cnt <= 1'b1;
          end
        end
        SOC: begin
          to_cnt <= to_cnt - TW'(1);
          state  <= CONV;
        end
        CONV: begin
          to_cnt <= to_cnt - TW'(1);
          if (eoc_edge) begin
            state <= LATCH;
          end
        end
        LATCH: begin
          fir_x_out     <= dout_in;
          ch_tag_out    <= cur_ch;
          fir_start_out <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          busy_out <= 1'b0;
        end
      endcase

      // Channel finished (sample latched or timed out): retire it and pick what comes next.
      if (ch_done) begin
        timeout_out <= conv_timeout;
        scan_mask   <= rest_mask;
        ptr         <= PW'(cur_ch) + PW'(1);
        if (!enable_in) begin
          state     <= IDLE;
          scan_mask <= '0;
          busy_out  <= 1'b0;
        end else if (rest_mask != '0) begin
          state <= SELECT;
        end else begin
          state    <= WAIT;
          busy_out <= 1'b0;
        end
      end
    end
  end

endmodule
